seq_detector_param: RTL and testbench

- Parametrised serial bit-pattern detector. It is the successor to the fixed 4-bit Mealy "1101" detector.
- Pattern and length are runtime-programmable up to PAT_W bits.
- Overlapping or non-overlapping match mode is selected by parameter.
- Input is qualified by a valid strobe.
- A saturating match counter is provided.
- Sits on a serial data path after the bit recovery stage. Drives event/interrupt logic.

---
 rtl/seq_detector_param.sv | 108 ++++++++++
 tb/tb_seq_detector_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Programmable serial bit-pattern detector with valid qualification and a saturating match counter.
// Optional macro SEQ_DET_MOORE_OUT_EN registers y one cycle after the final pattern bit.
module seq_detector_param #(
   parameter int               PAT_W       = 8,
   parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(8'b0000_1101),
   parameter int               DEF_LEN     = 4,
   parameter bit               OVERLAP     = 1'b1,
   parameter int               CNT_W       = 8,
   localparam int              LEN_W       = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x_valid,
   input  logic             x,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             cnt_clr,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_err
);

   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic [PAT_W-2:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cfg_err;

   logic [PAT_W-1:0] w_win;
   logic [PAT_W-1:0] w_mask;
   logic             w_pat_hit;
   logic             w_fill_ok;
   logic             w_match;
   logic             w_len_ok;

   assign w_win = {r_hist, x};

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         w_mask[i] = (i < r_len);
      end
   end

   // r_len is never 0, so len-1 cannot wrap
   assign w_pat_hit = (((w_win ^ r_pat) & w_mask) == '0);
   assign w_fill_ok = (r_fill >= (r_len - 1'b1));
   assign w_match   = x_valid & ~pat_load & ~reset & w_fill_ok & w_pat_hit;
   assign w_len_ok  = (len_in != '0) && (len_in <= LEN_W'(PAT_W));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pat     <= DEF_PATTERN;
         r_len     <= LEN_W'(DEF_LEN);
         r_hist    <= '0;
         r_fill    <= '0;
         r_cnt     <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= 1'b0;
         if (pat_load) begin
            r_fill <= '0;
            if (w_len_ok) begin
               r_pat <= pat_in;
               r_len <= len_in;
            end else begin
               r_cfg_err <= 1'b1;
            end
         end else if (x_valid) begin
            r_hist <= w_win[PAT_W-2:0];
            if (w_match && !OVERLAP) begin
               r_fill <= '0;
            end else if (r_fill < LEN_W'(PAT_W)) begin
               r_fill <= r_fill + 1'b1;
            end
         end
         // clear has priority over a same-cycle match
         if (cnt_clr) begin
            r_cnt <= '0;
         end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef SEQ_DET_MOORE_OUT_EN
   logic r_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_y <= 1'b0;
      end else begin
         r_y <= w_match;
      end
   end

   // a reset cycle masks a pending registered pulse
   assign y = r_y & ~reset;
`else
   assign y = w_match;
`endif

   assign match_cnt = r_cnt;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, non-overlap, 2-bit counter) against a bit-history model.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset, x_valid, x, pat_load, cnt_clr;
   logic [7:0] pat_in;
   logic [3:0] len_in;

   logic [2:0] y_o, err_o;
   logic [7:0] cnt_ov, cnt_nov;
   logic [1:0] cnt_c2;

   int ncmp  = 0;
   int nfail = 0;

   // model state per instance: 0 = overlap, 1 = non-overlap, 2 = overlap with 2-bit counter
   longint unsigned m_hist  [3];
   int              m_since [3];
   logic [7:0]      m_pat   [3];
   int              m_len   [3];
   int              m_cnt   [3];
   bit              m_err   [3];
   bit              m_prev  [3];
   bit              m_ov    [3] = '{1'b1, 1'b0, 1'b1};
   int              m_max   [3] = '{255, 255, 3};

   always #5 clk = ~clk;

   seq_detector_param #(.OVERLAP(1'b1)) u_ov (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .pat_load(pat_load),
      .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
      .y(y_o[0]), .match_cnt(cnt_ov), .cfg_err(err_o[0]));

   seq_detector_param #(.OVERLAP(1'b0)) u_nov (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .pat_load(pat_load),
      .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
      .y(y_o[1]), .match_cnt(cnt_nov), .cfg_err(err_o[1]));

   seq_detector_param #(.OVERLAP(1'b1), .CNT_W(2)) u_c2 (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .pat_load(pat_load),
      .pat_in(pat_in), .len_in(len_in), .cnt_clr(cnt_clr),
      .y(y_o[2]), .match_cnt(cnt_c2), .cfg_err(err_o[2]));

   function automatic int get_cnt(int k);
      case (k)
         0:       return int'(cnt_ov);
         1:       return int'(cnt_nov);
         default: return int'(cnt_c2);
      endcase
   endfunction

   task automatic check(string tag, int k, int got, int exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s[%0d]: observed %0d expected %0d", tag, k, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_hist[k] = 0; m_since[k] = 0; m_pat[k] = 8'b0000_1101; m_len[k] = 4;
         m_cnt[k] = 0;  m_err[k] = 1'b0; m_prev[k] = 1'b0;
      end
   endtask

   // match = the last len accepted bits (including the current one) equal the pattern,
   // and at least len bits were accepted since the last restart
   function automatic bit model_match(int k, bit rst, bit xv, bit xb, bit ld);
      longint unsigned w, msk;
      if (rst || !xv || ld) return 1'b0;
      if (m_since[k] + 1 < m_len[k]) return 1'b0;
      w   = (m_hist[k] << 1) | longint'(xb);
      msk = (64'd1 << m_len[k]) - 1;
      return (w & msk) == (longint'(m_pat[k]) & msk);
   endfunction

   task automatic step(bit rst, bit xv, bit xb, bit ld, logic [7:0] pin, logic [3:0] lin, bit clr);
      bit m [3];
      bit exp_y;
      @(negedge clk);
      reset = rst; x_valid = xv; x = xb; pat_load = ld; pat_in = pin; len_in = lin; cnt_clr = clr;
      #1;
      for (int k = 0; k < 3; k++) begin
         m[k] = model_match(k, rst, xv, xb, ld);
`ifdef SEQ_DET_MOORE_OUT_EN
         exp_y = m_prev[k] && !rst;
`else
         exp_y = m[k];
`endif
         check("y", k, int'(y_o[k]), int'(exp_y));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_hist[k] = 0; m_since[k] = 0; m_pat[k] = 8'b0000_1101; m_len[k] = 4;
            m_cnt[k] = 0;  m_err[k] = 1'b0; m_prev[k] = 1'b0;
         end else begin
            m_err[k] = 1'b0;
            if (ld) begin
               m_since[k] = 0;
               if (lin >= 1 && lin <= 8) begin
                  m_pat[k] = pin;
                  m_len[k] = int'(lin);
               end else begin
                  m_err[k] = 1'b1;
               end
            end else if (xv) begin
               m_hist[k]  = (m_hist[k] << 1) | longint'(xb);
               m_since[k] = (m[k] && !m_ov[k]) ? 0 : m_since[k] + 1;
            end
            if (clr) m_cnt[k] = 0;
            else if (m[k] && m_cnt[k] < m_max[k]) m_cnt[k]++;
            m_prev[k] = m[k];
         end
         check("match_cnt", k, get_cnt(k), m_cnt[k]);
         check("cfg_err", k, int'(err_o[k]), int'(m_err[k]));
      end
   endtask

   task automatic bits(logic [15:0] seq, int n);
      for (int i = n - 1; i >= 0; i--) step(0, 1, seq[i], 0, 8'h00, 4'd0, 0);
   endtask

   initial begin
      logic [7:0] rp;
      logic [3:0] rl;
      model_reset();
      reset = 1'b1; x_valid = 1'b0; x = 1'b0; pat_load = 1'b0;
      pat_in = '0; len_in = '0; cnt_clr = 1'b0;

      step(1, 0, 0, 0, 8'h00, 4'd0, 0);
      step(1, 0, 0, 0, 8'h00, 4'd0, 0);

      // 1101101 then 1101 in both overlap modes
      bits(16'b1101101, 7);
      check("t1_cnt", 0, int'(cnt_ov), 2);
      check("t2_cnt", 1, int'(cnt_nov), 1);
      bits(16'b1101, 4);
      check("t2_cnt_b", 1, int'(cnt_nov), 2);
      check("t1_cnt_b", 0, int'(cnt_ov), 3);

      // gap with x toggling while invalid
      step(1, 0, 0, 0, 8'h00, 4'd0, 0);
      bits(16'b11, 2);
      step(0, 0, 1, 0, 8'h00, 4'd0, 0);
      step(0, 0, 0, 0, 8'h00, 4'd0, 0);
      step(0, 0, 1, 0, 8'h00, 4'd0, 0);
      bits(16'b01, 2);
      check("t3_cnt", 0, int'(cnt_ov), 1);

      // load 010/3, legal; then illegal lengths 0 and 9
      step(0, 1, 1, 1, 8'b010, 4'd3, 0);
      bits(16'b01010, 5);
      step(0, 0, 0, 1, 8'hFF, 4'd0, 0);
      check("t4_err", 0, int'(err_o[0]), 1);
      step(0, 0, 0, 0, 8'h00, 4'd0, 0);
      check("t4_err_low", 0, int'(err_o[0]), 0);
      step(0, 0, 0, 1, 8'hFF, 4'd9, 0);
      bits(16'b010, 3);

      // counter saturation then clear against a match
      step(1, 0, 0, 0, 8'h00, 4'd0, 0);
      for (int r = 0; r < 5; r++) bits(16'b1101, 4);
      check("t5_sat", 2, int'(cnt_c2), 3);
      bits(16'b110, 3);
      step(0, 1, 1, 0, 8'h00, 4'd0, 1);
      check("t5_clr", 2, int'(cnt_c2), 0);

      // reset mid-sequence restarts the fill
      bits(16'b110, 3);
      step(1, 1, 1, 0, 8'h00, 4'd0, 0);
      step(0, 1, 1, 0, 8'h00, 4'd0, 0);

      // len=1 in both modes
      step(0, 0, 0, 1, 8'h01, 4'd1, 0);
      bits(16'b1011, 4);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         rp = 8'($urandom);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 24) == 0, rp, rl, $urandom_range(0, 19) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
